// File: rtl/c499_key_loader.sv
// Serial key loader for the locked c499 corrector: shifts in a 12-bit parity-protected
// key frame, checks it, commits the 11 key bits atomically and gates the N137 enable.
module c499_key_loader #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic key_start,
  input  logic key_sdi,
  input  logic key_sdi_vld,
  output logic key_sdi_rdy,
  input  logic N137_in,
  output logic N137,
  output logic p1,
  output logic p2,
  output logic p3,
  output logic p4,
  output logic X_1,
  output logic X_2,
  output logic X_3,
  output logic X_4,
  output logic X_5,
  output logic X_6,
  output logic X_7,
  output logic key_valid,
  output logic key_err,
  output logic busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [3:0] BIT_LAST = 4'd11;

  function automatic logic parity_ok(input logic [11:0] frame);
    return (^frame) == 1'b0;
  endfunction

  state_t      r_state;
  state_t      w_next;
  logic [11:0] r_shift;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_to_cnt;
  logic [10:0] r_key;
  logic        r_key_valid;
  logic        r_key_err;

  logic w_accept;
  logic w_restart;
  logic w_abort;
  logic w_bad;
  logic w_commit;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a start pulse in SHIFT restarts rather than leaving
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (key_start) w_next = ST_SHIFT;
        else           w_next = ST_IDLE;
      end
      ST_SHIFT: begin
        if (key_start)                                  w_next = ST_SHIFT;
        else if (w_accept && (r_bit_cnt == BIT_LAST))   w_next = ST_CHECK;
        else if (!w_accept && (r_to_cnt == TO_LAST))    w_next = ST_IDLE;
        else                                            w_next = ST_SHIFT;
      end
      ST_CHECK: begin
        if (parity_ok(r_shift)) w_next = ST_COMMIT;
        else                    w_next = ST_IDLE;
      end
      ST_COMMIT: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Output and control decode from the current state
  always_comb begin
    key_sdi_rdy = 1'b0;
    busy        = 1'b1;
    w_restart   = 1'b0;
    w_abort     = 1'b0;
    w_bad       = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy      = 1'b0;
        w_restart = key_start;
      end
      ST_SHIFT: begin
        key_sdi_rdy = 1'b1;
        w_restart   = key_start;
        w_abort     = !key_start && !key_sdi_vld && (r_to_cnt == TO_LAST);
      end
      ST_CHECK: begin
        w_bad = !parity_ok(r_shift);
      end
      ST_COMMIT: begin
        w_commit = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign w_accept = key_sdi_vld && key_sdi_rdy;

  // Shift register, bit counter and inter-bit timeout counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift   <= 12'd0;
      r_bit_cnt <= 4'd0;
      r_to_cnt  <= 8'd0;
    end else if (w_restart) begin
      r_shift   <= 12'd0;
      r_bit_cnt <= 4'd0;
      r_to_cnt  <= 8'd0;
    end else if (w_accept) begin
      r_shift   <= {r_shift[10:0], key_sdi};
      r_bit_cnt <= r_bit_cnt + 4'd1;
      r_to_cnt  <= 8'd0;
    end else if (r_state == ST_SHIFT) begin
      r_to_cnt  <= r_to_cnt + 8'd1;
    end else begin
      r_shift   <= r_shift;
    end
  end

  // Committed key and status flags; the finishing frame's outcome beats a start pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key       <= 11'd0;
      r_key_valid <= 1'b0;
      r_key_err   <= 1'b0;
    end else begin
      if (w_commit) begin
        r_key       <= r_shift[11:1];
        r_key_valid <= 1'b1;
      end else begin
        r_key       <= r_key;
        r_key_valid <= r_key_valid;
      end
      if (w_commit)              r_key_err <= 1'b0;
      else if (w_abort || w_bad) r_key_err <= 1'b1;
      else if (key_start)        r_key_err <= 1'b0;
      else                       r_key_err <= r_key_err;
    end
  end

  assign {p1, p2, p3, p4, X_1, X_2, X_3, X_4, X_5, X_6, X_7} = r_key;
  assign key_valid = r_key_valid;
  assign key_err   = r_key_err;
  assign N137      = N137_in & r_key_valid;

endmodule

// File: tb/tb_c499_key_loader.sv
// Directed bench for c499_key_loader: a frame table plus hand sequences for latency,
// bad parity timing, timeout, restart and mid-frame reset.
module tb_c499_key_loader;

  logic clk = 1'b0;
  logic reset, key_start, key_sdi, key_sdi_vld, N137_in;
  logic key_sdi_rdy, N137, key_valid, key_err, busy;
  logic p1, p2, p3, p4, X_1, X_2, X_3, X_4, X_5, X_6, X_7;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  c499_key_loader #(.TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .key_start(key_start), .key_sdi(key_sdi),
    .key_sdi_vld(key_sdi_vld), .key_sdi_rdy(key_sdi_rdy), .N137_in(N137_in), .N137(N137),
    .p1(p1), .p2(p2), .p3(p3), .p4(p4),
    .X_1(X_1), .X_2(X_2), .X_3(X_3), .X_4(X_4), .X_5(X_5), .X_6(X_6), .X_7(X_7),
    .key_valid(key_valid), .key_err(key_err), .busy(busy)
  );

  typedef struct {
    logic [11:0] frame;
    logic [10:0] exp_key;
    logic        exp_valid;
    logic        exp_err;
  } vec_t;

  localparam logic [10:0] K1 = 11'b1010_1100101;
  localparam logic [10:0] K2 = 11'b1100_0000001;
  localparam logic [10:0] K3 = 11'b0111_0011010;

  function automatic logic [10:0] key_out();
    return {p1, p2, p3, p4, X_1, X_2, X_3, X_4, X_5, X_6, X_7};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bits(input logic [11:0] frame);
    for (int i = 11; i >= 0; i--) begin
      key_sdi_vld = 1'b1;
      key_sdi     = frame[i];
      tick(1);
    end
    key_sdi_vld = 1'b0;
    key_sdi     = 1'b0;
  endtask

  task automatic pulse_start();
    key_start = 1'b1;
    tick(1);
    key_start = 1'b0;
  endtask

  task automatic send_frame(input logic [11:0] frame);
    pulse_start();
    send_bits(frame);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{frame: {K1, 1'b1},          exp_key: K1, exp_valid: 1'b1, exp_err: 1'b1};
    vecs[1] = '{frame: {K2, 1'b1},          exp_key: K2, exp_valid: 1'b1, exp_err: 1'b0};
    vecs[2] = '{frame: {K2, 1'b0},          exp_key: K2, exp_valid: 1'b1, exp_err: 1'b1};
    vecs[3] = '{frame: {K3, 1'b0},          exp_key: K3, exp_valid: 1'b1, exp_err: 1'b0};
    vecs[4] = '{frame: {K3 ^ 11'd1, 1'b0},  exp_key: K3, exp_valid: 1'b1, exp_err: 1'b1};

    reset = 1'b1; key_start = 1'b0; key_sdi = 1'b0; key_sdi_vld = 1'b0; N137_in = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Reset state
    chk("rst_key",   32'(key_out()), 32'd0);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_n137",  32'(N137), 32'd0);
    chk("rst_rdy",   32'(key_sdi_rdy), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);

    // First good frame: visible exactly 15 cycles after key_start
    key_start = 1'b1;
    tick(1);
    key_start = 1'b0;
    chk("start_rdy", 32'(key_sdi_rdy), 32'd1);
    send_bits({K1, 1'b0});
    tick(1);
    chk("lat14_valid", 32'(key_valid), 32'd0);
    chk("lat14_busy",  32'(busy), 32'd1);
    tick(1);
    chk("lat15_key",   32'(key_out()), 32'(K1));
    chk("lat15_valid", 32'(key_valid), 32'd1);
    chk("lat15_busy",  32'(busy), 32'd0);
    chk("n137_on",     32'(N137), 32'd1);
    N137_in = 1'b0;
    #1;
    chk("n137_off",    32'(N137), 32'd0);
    N137_in = 1'b1;

    // Frame table
    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].frame);
      tick(2);
      chk($sformatf("vec%0d_key", v),   32'(key_out()), 32'(vecs[v].exp_key));
      chk($sformatf("vec%0d_valid", v), 32'(key_valid), 32'(vecs[v].exp_valid));
      chk($sformatf("vec%0d_err", v),   32'(key_err), 32'(vecs[v].exp_err));
      chk($sformatf("vec%0d_busy", v),  32'(busy), 32'd0);
    end

    // Bad parity: key_err rises two cycles after the 12th bit
    send_frame({K1, 1'b1});
    chk("bad_t1_err",  32'(key_err), 32'd0);
    chk("bad_t1_busy", 32'(busy), 32'd1);
    tick(1);
    chk("bad_t2_err",  32'(key_err), 32'd1);
    chk("bad_t2_busy", 32'(busy), 32'd0);
    chk("bad_key",     32'(key_out()), 32'(K3));

    // Timeout after 5 bits
    pulse_start();
    chk("to_start_clr", 32'(key_err), 32'd0);
    for (int i = 0; i < 5; i++) begin
      key_sdi_vld = 1'b1;
      key_sdi     = 1'b1;
      tick(1);
    end
    key_sdi_vld = 1'b0;
    tick(63);
    chk("to_pre_busy", 32'(busy), 32'd1);
    chk("to_pre_err",  32'(key_err), 32'd0);
    tick(1);
    chk("to_busy",  32'(busy), 32'd0);
    chk("to_err",   32'(key_err), 32'd1);
    chk("to_key",   32'(key_out()), 32'(K3));
    chk("to_valid", 32'(key_valid), 32'd1);
    pulse_start();
    chk("to_err_clr", 32'(key_err), 32'd0);

    // Restart after 7 bits, coincident with a valid bit, then all-zero good frame
    for (int i = 0; i < 7; i++) begin
      key_sdi_vld = 1'b1;
      key_sdi     = 1'b1;
      tick(1);
    end
    key_start = 1'b1;
    key_sdi_vld = 1'b1;
    key_sdi = 1'b1;
    tick(1);
    key_start = 1'b0;
    chk("rs_rdy", 32'(key_sdi_rdy), 32'd1);
    send_bits(12'd0);
    tick(2);
    chk("rs_key",   32'(key_out()), 32'd0);
    chk("rs_valid", 32'(key_valid), 32'd1);
    chk("rs_err",   32'(key_err), 32'd0);
    chk("rs_busy",  32'(busy), 32'd0);

    // Reset during bit 9 after a valid commit
    send_frame({K1, 1'b0});
    tick(2);
    chk("pre_rst_key", 32'(key_out()), 32'(K1));
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      key_sdi_vld = 1'b1;
      key_sdi     = 1'b1;
      tick(1);
    end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    key_sdi_vld = 1'b0;
    chk("mr_key",   32'(key_out()), 32'd0);
    chk("mr_valid", 32'(key_valid), 32'd0);
    chk("mr_n137",  32'(N137), 32'd0);
    chk("mr_busy",  32'(busy), 32'd0);
    chk("mr_rdy",   32'(key_sdi_rdy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/c499_key_loader.md
# c499_key_loader

Serial key-programming stage that sits directly upstream of the locked c499 SEC corrector. It receives an 11-bit key frame plus parity over a bit-serial handshake, checks it, and commits it atomically to the key outputs (p1..p4, X_1..X_7). It also gates the corrector's N137 enable, so correction is inhibited until a valid key is held.

## Interface
- TIMEOUT, default 64: idle cycles allowed between bits within a frame before the frame is aborted; 2..255.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- key_start  in  1  one-cycle pulse that opens a new frame.
- key_sdi  in  1  serial key data bit.
- key_sdi_vld  in  1  key_sdi is valid this cycle.
- key_sdi_rdy  out  1  loader accepts a bit this cycle.
- N137_in  in  1  upstream correction enable.
- N137  out  1  gated enable to the corrector: N137_in AND key_valid (combinational).
- p1, p2, p3, p4  out  1 each  committed mux-key bits.
- X_1..X_7  out  1 each  committed XOR-key bits.
- key_valid  out  1  a parity-checked key is committed.
- key_err  out  1  sticky error flag for the last frame.
- busy  out  1  a frame is in progress (any state other than IDLE).

## Operation
- Frame: 12 bits, first bit first, in the order p1, p2, p3, p4, X_1..X_7, then P. P is chosen so that the XOR of all 12 bits is 0 (even parity).
- States:
  - IDLE -> SHIFT on key_start.
  - SHIFT -> CHECK when the 12th bit is accepted.
  - SHIFT -> IDLE on timeout, setting key_err.
  - CHECK -> COMMIT if parity is good; CHECK -> IDLE if parity is bad, setting key_err.
  - COMMIT -> IDLE.
- SHIFT:
  - key_sdi_rdy = 1 only in SHIFT.
  - A bit is accepted when key_sdi_vld = 1 and rdy = 1. It enters a 12-bit shift register, and the 4-bit bit counter increments (0..11).
- Timeout counter (8-bit):
  - clears on every accepted bit and on entry to SHIFT.
  - increments on each SHIFT cycle with no accepted bit.
  - reaching TIMEOUT aborts the frame.
- CHECK: one cycle; XOR-reduces the 12 captured bits.
- COMMIT: one cycle.
  - The 11 key bits are written to the output register together; no partial update is ever visible.
  - key_valid is set to 1 and key_err is cleared.
- Rejected or aborted frames leave the previously committed key and key_valid unchanged.
- key_start:
  - clears key_err in any state.
  - In SHIFT, it restarts the frame: counter and timeout clear, captured bits are discarded, and the FSM stays in SHIFT.
  - In CHECK or COMMIT, it is ignored and the current frame finishes.
- key_start together with an accepted bit in the same cycle: the restart wins and the bit is discarded.

## Timing
- Reset (synchronous): state = IDLE; p1..p4 = 0, X_1..X_7 = 0, key_valid = 0, key_err = 0, busy = 0, key_sdi_rdy = 0. N137 = 0 regardless of N137_in.
- Reset asserted mid-frame: the frame is discarded, and the committed key clears to 0 on the next edge.
- key_start in cycle t -> SHIFT and rdy = 1 in cycle t+1.
- Back-to-back bits: 12 cycles in SHIFT.
- 12th bit accepted in cycle t:
  - CHECK in t+1, COMMIT in t+2.
  - New key bits and key_valid = 1 are visible from t+3.
  - busy deasserts in t+3.
- Minimum start-to-valid latency: 15 cycles.
- Bad parity: key_err = 1 from t+2, and the FSM is in IDLE from t+2.
- Timeout: with the last accepted bit (or SHIFT entry) in cycle s, the abort occurs when the counter reaches TIMEOUT. key_err = 1 and the FSM returns to IDLE on that edge.
- N137 is combinational from N137_in and key_valid; no added latency.

## Test plan
- After reset, check: key outputs = 0, key_valid = 0, N137 = 0 with N137_in = 1, key_sdi_rdy = 0.
- Send frame bits 1,0,1,0, 1,1,0,0,1,0,1 with P = 0 (six ones), back-to-back:
  - expected: p1..p4 = 1,0,1,0 and X_1..X_7 = 1,1,0,0,1,0,1, visible exactly 15 cycles after key_start;
  - key_valid = 1; N137 follows N137_in.
- Same frame with P = 1:
  - expected: key_err = 1 two cycles after the 12th bit;
  - the previous key is unchanged and key_valid is unchanged.
- Send 5 bits, then hold key_sdi_vld = 0 for TIMEOUT = 64 cycles:
  - expected: abort to IDLE, key_err = 1, key unchanged;
  - a following key_start clears key_err.
- Pulse key_start after 7 bits, in the same cycle as a valid bit, then send a full good frame of all-zero bits (P = 0):
  - expected: the old bits and the coincident bit are discarded;
  - all key outputs are 0 and key_valid = 1 after commit.
- Assert reset during bit 9 of a frame, after a prior valid commit:
  - expected: key outputs and key_valid are 0 next cycle, N137 = 0, FSM in IDLE.
